// File: rtl/id_pkg.sv
// Shared types and defaults for the decode-issue front end.
// Register index width, default architectural sizes and the buffered entry layout.
// Pure declarations; no logic.
package id_pkg;

  localparam int REG_IDX_W = 5;
  localparam int NREG_DEF  = 32;
  localparam int XLEN_DEF  = 32;

  // One buffered instruction as it travels from IF to the decoder.
  typedef struct packed {
    logic [XLEN_DEF-1:0] pc;
    logic [XLEN_DEF-1:0] inst;
  } fifo_ent_t;

endpackage

// File: rtl/id_scoreboard.sv
// Per-register pending-write counters with issue increment and writeback decrement.
// Latency: updates visible one cycle after the inc/dec edge; lookups are combinational.
// No backpressure; a counter at max is reported so the issuer stalls instead of overflowing.
module id_scoreboard
  import id_pkg::*;
#(
  parameter int NREG   = NREG_DEF,
  parameter int PEND_W = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inc_i,
  input  logic [REG_IDX_W-1:0] inc_idx_i,
  input  logic                 dec_i,
  input  logic [REG_IDX_W-1:0] dec_idx_i,
  input  logic [REG_IDX_W-1:0] src1_idx_i,
  input  logic [REG_IDX_W-1:0] src2_idx_i,
  input  logic [REG_IDX_W-1:0] dest_idx_i,
  output logic                 src1_busy_o,
  output logic                 src2_busy_o,
  output logic                 dest_full_o
);

  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  logic [PEND_W-1:0] pend_q [NREG];
  logic [PEND_W-1:0] pend_d [NREG];

  // Next counter values: inc and dec on the same register cancel; dec saturates at zero; r0 never moves.
  always_comb begin
    logic up;
    logic dn;
    up = 1'b0;
    dn = 1'b0;
    for (int r = 0; r < NREG; r++) begin
      pend_d[r] = pend_q[r];
      up = inc_i && (inc_idx_i == REG_IDX_W'(r));
      dn = dec_i && (dec_idx_i == REG_IDX_W'(r));
      if (r != 0) begin
        if (up && !dn && (pend_q[r] != PEND_MAX)) begin
          pend_d[r] = pend_q[r] + 1'b1;
        end else if (dn && !up && (pend_q[r] != '0)) begin
          pend_d[r] = pend_q[r] - 1'b1;
        end
      end
    end
  end

  // Counter state register with synchronous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) begin
        pend_q[r] <= '0;
      end
    end else begin
      pend_q <= pend_d;
    end
  end

  assign src1_busy_o = (src1_idx_i != '0) && (pend_q[src1_idx_i] != '0);
  assign src2_busy_o = (src2_idx_i != '0) && (pend_q[src2_idx_i] != '0);
  assign dest_full_o = (dest_idx_i != '0) && (pend_q[dest_idx_i] == PEND_MAX);

endmodule

// File: rtl/id_issue_buf.sv
// Decode-issue buffer: FIFO of fetched instructions, scoreboard-gated issue, branch flush.
// Latency: enqueue in cycle N is at the head in N+1; head issues combinationally when hazard-free.
// Backpressure: o_id_ready drops when full; head holds while hazard_stall or i_ex_ready low.
module id_issue_buf
  import id_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int XLEN   = XLEN_DEF,
  parameter int NREG   = NREG_DEF,
  parameter int PEND_W = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       if_to_id_valid,
  input  logic [XLEN-1:0]            if_to_id_pc,
  input  logic [XLEN-1:0]            if_to_id_inst,
  output logic                       o_id_ready,
  output logic                       head_valid,
  output logic [XLEN-1:0]            head_pc,
  output logic [XLEN-1:0]            head_inst,
  input  logic                       id_src1_en,
  input  logic [REG_IDX_W-1:0]       id_src1,
  input  logic                       id_src2_en,
  input  logic [REG_IDX_W-1:0]       id_src2,
  input  logic                       id_dest_we,
  input  logic [REG_IDX_W-1:0]       id_dest,
  input  logic                       br_taken,
  input  logic                       i_ex_ready,
  output logic                       id_to_ex_valid,
  output logic                       hazard_stall,
  input  logic                       wb_valid,
  input  logic [REG_IDX_W-1:0]       wb_waddr,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  fifo_ent_t        mem_q [DEPTH];
  logic [PTR_W-1:0] rd_q, rd_d;
  logic [PTR_W-1:0] wr_q, wr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             enq, fire, flush;
  logic             src1_busy, src2_busy, dest_full;

  // Full/empty come from the count; ready ignores a same-cycle dequeue.
  assign o_id_ready     = ~rst & (cnt_q < CNT_W'(DEPTH));
  assign head_valid     = ~rst & (cnt_q != '0);
  assign head_pc        = XLEN'(mem_q[rd_q].pc);
  assign head_inst      = XLEN'(mem_q[rd_q].inst);
  assign hazard_stall   = head_valid & ((id_src1_en & src1_busy) |
                                        (id_src2_en & src2_busy) |
                                        (id_dest_we & dest_full));
  assign id_to_ex_valid = head_valid & ~hazard_stall;
  assign fire           = id_to_ex_valid & i_ex_ready;
  // A taken branch only counts when it actually issues.
  assign flush          = br_taken & fire;
  assign enq            = if_to_id_valid & o_id_ready & ~flush;
  assign fifo_count     = cnt_q;

  // Pointer/count next state; a flush empties the buffer and drops any concurrent enqueue.
  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (flush) begin
      rd_d  = wr_q;
      cnt_d = '0;
    end else begin
      if (enq)  wr_d = wr_q + 1'b1;
      if (fire) rd_d = rd_q + 1'b1;
      case ({enq, fire})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // Control state register with synchronous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  // Entry storage; contents are only meaningful below the count, so no reset is needed.
  always_ff @(posedge clk) begin
    if (enq) begin
      mem_q[wr_q] <= '{pc: XLEN_DEF'(if_to_id_pc), inst: XLEN_DEF'(if_to_id_inst)};
    end
  end

  id_scoreboard #(
    .NREG   (NREG),
    .PEND_W (PEND_W)
  ) u_sb (
    .clk         (clk),
    .rst         (rst),
    .inc_i       (fire & id_dest_we),
    .inc_idx_i   (id_dest),
    .dec_i       (wb_valid),
    .dec_idx_i   (wb_waddr),
    .src1_idx_i  (id_src1),
    .src2_idx_i  (id_src2),
    .dest_idx_i  (id_dest),
    .src1_busy_o (src1_busy),
    .src2_busy_o (src2_busy),
    .dest_full_o (dest_full)
  );

endmodule
